// File: rtl/packet_framer_if.sv
// Segment-stream bundle between the splitter FIFO, the packet framer and the line encoder.
// The framer side (master) pops upstream segments and drives the outgoing frame stream.
interface packet_framer_if #(
  parameter int SEGMENT_SIZE = 4
);
  logic                    in_nempty;
  logic [SEGMENT_SIZE-1:0] in_data;
  logic                    in_end;
  logic                    in_pop;
  logic                    out_valid;
  logic                    out_ready;
  logic [SEGMENT_SIZE-1:0] out_data;
  logic                    out_frame;
  logic                    out_last;

  modport master (
    input  in_nempty,
    input  in_data,
    input  in_end,
    input  out_ready,
    output in_pop,
    output out_valid,
    output out_data,
    output out_frame,
    output out_last
  );

  modport slave (
    output in_nempty,
    output in_data,
    output in_end,
    output out_ready,
    input  in_pop,
    input  out_valid,
    input  out_data,
    input  out_frame,
    input  out_last
  );
endinterface

// File: rtl/packet_framer.sv
// Wraps upstream payload segments into line frames: preamble, sync, payload, CRC-8, then an
// idle gap. All outputs decode from registered state so reset clears them asynchronously.
module packet_framer #(
  parameter int                      SEGMENT_SIZE    = 4,
  parameter int                      PREAMBLE_LENGTH = 4,
  parameter logic [SEGMENT_SIZE-1:0] PREAMBLE_SYMBOL = 4'h5,
  parameter logic [SEGMENT_SIZE-1:0] SYNC_SYMBOL     = 4'hD,
  parameter int                      GAP_CYCLES      = 2
) (
  input logic             clk,
  input logic             rst,
  packet_framer_if.master bus
);

  localparam int CRC_SEGS  = 8 / SEGMENT_SIZE;
  localparam int MAX_PG    = (PREAMBLE_LENGTH > GAP_CYCLES) ? PREAMBLE_LENGTH : GAP_CYCLES;
  localparam int MAX_COUNT = (MAX_PG > CRC_SEGS) ? MAX_PG : CRC_SEGS;
  localparam int CNT_W     = $clog2(MAX_COUNT + 1);

  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LENGTH - 1);
  localparam logic [CNT_W-1:0] CRC_LAST = CNT_W'(CRC_SEGS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  if (SEGMENT_SIZE != 1 && SEGMENT_SIZE != 2 && SEGMENT_SIZE != 4 && SEGMENT_SIZE != 8)
  begin : g_bad_segment_size
    $error("packet_framer: SEGMENT_SIZE must be 1, 2, 4 or 8");
  end
  if (PREAMBLE_LENGTH < 1) begin : g_bad_preamble_length
    $error("packet_framer: PREAMBLE_LENGTH must be at least 1");
  end
  if (PREAMBLE_SYMBOL == SYNC_SYMBOL) begin : g_bad_symbols
    $error("packet_framer: SYNC_SYMBOL must differ from PREAMBLE_SYMBOL");
  end
  if (GAP_CYCLES < 0) begin : g_bad_gap
    $error("packet_framer: GAP_CYCLES must not be negative");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_SYNC,
    S_PAYLOAD,
    S_CRC,
    S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       crc_q, crc_d;

  logic                    pop;
  logic                    emit_valid;
  logic [SEGMENT_SIZE-1:0] emit_data;
  logic                    emit_frame;
  logic                    emit_last;
  logic [7:0]              crc_shift;

  // CRC-8 poly 0x07, shifting the segment in MSB first.
  function automatic logic [7:0] crc_step(input logic [7:0]              crc,
                                          input logic [SEGMENT_SIZE-1:0] seg);
    logic [7:0] c;
    c = crc;
    for (int i = SEGMENT_SIZE - 1; i >= 0; i--) begin
      c = {c[6:0], 1'b0} ^ ((c[7] ^ seg[i]) ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  // Most significant CRC segment goes out first.
  assign crc_shift = crc_q << (count_q * SEGMENT_SIZE);

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      crc_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      crc_q   <= crc_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    crc_d      = crc_q;
    pop        = 1'b0;
    emit_valid = 1'b0;
    emit_data  = '0;
    emit_frame = 1'b0;
    emit_last  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_nempty) begin
          state_d = S_PREAMBLE;
          count_d = '0;
          crc_d   = 8'h00;
        end
      end

      S_PREAMBLE: begin
        emit_valid = 1'b1;
        emit_frame = 1'b1;
        emit_data  = PREAMBLE_SYMBOL;
        if (bus.out_ready) begin
          count_d = count_q + 1'b1;
          if (count_q == PRE_LAST) begin
            state_d = S_SYNC;
          end
        end
      end

      S_SYNC: begin
        emit_valid = 1'b1;
        emit_frame = 1'b1;
        emit_data  = SYNC_SYMBOL;
        if (bus.out_ready) begin
          state_d = S_PAYLOAD;
        end
      end

      // Pass-through: a stalled upstream drops out_valid but keeps the frame open.
      S_PAYLOAD: begin
        emit_frame = 1'b1;
        emit_valid = bus.in_nempty;
        emit_data  = bus.in_data;
        pop        = bus.in_nempty && bus.out_ready;
        if (pop) begin
          crc_d = crc_step(crc_q, bus.in_data);
          if (bus.in_end) begin
            state_d = S_CRC;
            count_d = '0;
          end
        end
      end

      S_CRC: begin
        emit_valid = 1'b1;
        emit_frame = 1'b1;
        emit_data  = crc_shift[7 -: SEGMENT_SIZE];
        emit_last  = (count_q == CRC_LAST);
        if (bus.out_ready) begin
          if (count_q == CRC_LAST) begin
            count_d = '0;
            state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end

      S_GAP: begin
        count_d = count_q + 1'b1;
        if (count_q == GAP_LAST) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.in_pop    = pop;
  assign bus.out_valid = emit_valid;
  assign bus.out_data  = emit_data;
  assign bus.out_frame = emit_frame;
  assign bus.out_last  = emit_last;

  pop_only_in_payload: assert property (
    @(posedge clk) disable iff (rst) bus.in_pop |-> (state_q == S_PAYLOAD) && bus.out_ready
  );

  last_needs_valid: assert property (
    @(posedge clk) disable iff (rst) bus.out_last |-> bus.out_valid && bus.out_frame
  );

  // Outside PAYLOAD the emitted segment is generated locally and must hold under backpressure.
  hold_under_backpressure: assert property (
    @(posedge clk) disable iff (rst)
      (bus.out_valid && !bus.out_ready && state_q != S_PAYLOAD)
      |=> (bus.out_valid && $stable(bus.out_data))
  );

endmodule

// File: tb/tb_packet_framer.sv
// Directed bench for packet_framer: hand-computed frames checked segment by segment, plus
// backpressure, upstream stall, back-to-back spacing and mid-frame reset scenarios.
module tb_packet_framer;
  localparam int         SEG      = 4;
  localparam int         PRE_LEN  = 4;
  localparam int         GAP      = 2;
  localparam logic [3:0] PRE_SYM  = 4'h5;
  localparam logic [3:0] SYNC_SYM = 4'hD;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  packet_framer_if #(.SEGMENT_SIZE(SEG)) bus ();

  packet_framer #(
    .SEGMENT_SIZE   (SEG),
    .PREAMBLE_LENGTH(PRE_LEN),
    .PREAMBLE_SYMBOL(PRE_SYM),
    .SYNC_SYMBOL    (SYNC_SYM),
    .GAP_CYCLES     (GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Upstream model and stimulus controls (owned by the main initial block).
  logic [4:0] up_q[$];
  logic [4:0] exp_q[$];
  int         stall_cnt = 0;
  int         stall_at  = -1;
  int         pops_drv  = 0;
  bit         rdy_rand  = 1'b0;

  // Observations (owned by the monitor).
  logic [4:0] got[$];
  int         starts[$];
  int         lasts[$];
  int         cyc        = 0;
  bit         pop_seen   = 1'b0;
  bit         in_frame   = 1'b0;
  bit         between    = 1'b0;
  int         since_last = 1000;
  int         pops_total = 0;
  int         pop_nr     = 0;
  int         gap_pops   = 0;
  int         gap_bad    = 0;
  int         stall_seen = 0;
  int         stall_bad  = 0;
  int         hold_bad   = 0;
  bit         prev_vnr   = 1'b0;
  logic [3:0] prev_data  = 4'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_tests++;
    if (obs !== req) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, obs, req);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    pop_seen = bus.in_pop;
    if (since_last < 1000) since_last++;
    if (rst) begin
      in_frame   = 1'b0;
      between    = 1'b0;
      prev_vnr   = 1'b0;
      since_last = 1000;
    end else begin
      if (bus.in_pop) pops_total++;
      if (bus.in_pop && !bus.out_ready) pop_nr++;
      if (between && bus.in_pop) gap_pops++;
      if (since_last >= 1 && since_last <= GAP && (bus.out_valid || bus.out_frame)) gap_bad++;
      if (stall_cnt > 0) begin
        stall_seen++;
        if (bus.out_valid || !bus.out_frame) stall_bad++;
      end
      if (prev_vnr && (!bus.out_valid || bus.out_data != prev_data)) hold_bad++;
      prev_vnr  = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
      if (bus.out_valid && bus.out_ready) begin
        got.push_back({bus.out_last, bus.out_data});
        if (!in_frame) starts.push_back(cyc);
        in_frame = 1'b1;
        between  = 1'b0;
        if (bus.out_last) begin
          lasts.push_back(cyc);
          in_frame   = 1'b0;
          between    = 1'b1;
          since_last = 0;
        end
      end
    end
  end

  task automatic drive_inputs();
    bus.in_nempty = (up_q.size() > 0) && (stall_cnt == 0);
    bus.in_data   = (up_q.size() > 0) ? up_q[0][3:0] : 4'h0;
    bus.in_end    = (up_q.size() > 0) ? up_q[0][4] : 1'b0;
    bus.out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  // One clock: retire the segment popped in the cycle just ended, then present the next inputs.
  task automatic step();
    @(posedge clk);
    #1;
    if (pop_seen) begin
      if (up_q.size() > 0) void'(up_q.pop_front());
      pops_drv++;
      if (pops_drv == stall_at) stall_cnt = 5;
    end else if (stall_cnt > 0) begin
      stall_cnt--;
    end
    drive_inputs();
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_frames(input string tag, input int n_lasts, input int budget);
    int k;
    k = 0;
    while (lasts.size() < n_lasts && k < budget) begin
      step();
      k++;
    end
    check(tag, lasts.size(), n_lasts);
  endtask

  task automatic load_packet(input logic [3:0] pl[$]);
    for (int i = 0; i < pl.size(); i++) up_q.push_back({(i == pl.size() - 1), pl[i]});
    drive_inputs();
  endtask

  task automatic expect_frame(input logic [3:0] pl[$], input logic [7:0] crc);
    for (int i = 0; i < PRE_LEN; i++) exp_q.push_back({1'b0, PRE_SYM});
    exp_q.push_back({1'b0, SYNC_SYM});
    for (int i = 0; i < pl.size(); i++) exp_q.push_back({1'b0, pl[i]});
    exp_q.push_back({1'b0, crc[7:4]});
    exp_q.push_back({1'b1, crc[3:0]});
  endtask

  task automatic compare_frames(input string tag, input int base);
    logic [31:0] obs;
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (base + i < got.size()) ? 32'(got[base + i]) : 32'hFFFF_FFFF;
      check($sformatf("%s[%0d]", tag, i), obs, 32'(exp_q[i]));
    end
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] p_std[$];
    logic [3:0] p_zero[$];
    logic [3:0] p_one[$];
    logic [3:0] p_a[$];
    int base, n_l, n_s, pops0, stall0;

    // "123456789" as ASCII, high nibble first; CRC-8/SMBUS of it is 0xF4.
    for (int k = 1; k <= 9; k++) begin
      p_std.push_back(4'h3);
      p_std.push_back(4'(k));
    end
    p_zero.push_back(4'h0);
    p_one.push_back(4'h1);
    p_a.push_back(4'hA);

    bus.in_nempty = 1'b0;
    bus.in_data   = 4'h0;
    bus.in_end    = 1'b0;
    bus.out_ready = 1'b1;

    #1 rst = 1'b1;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_pop",    bus.in_pop,    0);
    check("rst_out_data",  bus.out_data,  0);
    check("rst_out_frame", bus.out_frame, 0);
    check("rst_out_last",  bus.out_last,  0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reference frame with out_ready held high.
    base = got.size();
    load_packet(p_std);
    run_frames("t1_done", 1, 200);
    expect_frame(p_std, 8'hF4);
    compare_frames("t1_seg", base);
    check("t1_span", lasts[0] - starts[0] + 1, PRE_LEN + 1 + 18 + 2);
    settle(GAP + 3);
    check("t1_gap_quiet", gap_bad, 0);

    // Single zero segment: payload length 1, CRC 0x00.
    base  = got.size();
    pops0 = pops_total;
    load_packet(p_zero);
    run_frames("t2_done", 2, 100);
    expect_frame(p_zero, 8'h00);
    compare_frames("t2_seg", base);
    check("t2_pops", pops_total - pops0, 1);
    check("t2_count", got.size() - base, 8);
    settle(GAP + 3);

    // Random backpressure.
    base     = got.size();
    rdy_rand = 1'b1;
    load_packet(p_std);
    run_frames("t3_done", 3, 400);
    rdy_rand = 1'b0;
    settle(GAP + 3);
    expect_frame(p_std, 8'hF4);
    compare_frames("t3_seg", base);
    check("t3_count", got.size() - base, 25);
    check("t3_pop_while_not_ready", pop_nr, 0);
    check("t3_hold", hold_bad, 0);

    // Upstream stall of 5 cycles after the 6th payload pop.
    base     = got.size();
    stall0   = stall_seen;
    stall_at = pops_drv + 6;
    load_packet(p_std);
    run_frames("t4_done", 4, 200);
    stall_at = -1;
    expect_frame(p_std, 8'hF4);
    compare_frames("t4_seg", base);
    check("t4_stall_cycles", stall_seen - stall0, 5);
    check("t4_stall_outputs", stall_bad, 0);
    settle(GAP + 3);

    // Two packets queued back to back: A (CRC 0x36) then 1 (CRC 0x07).
    base = got.size();
    n_l  = lasts.size();
    n_s  = starts.size();
    load_packet(p_a);
    load_packet(p_one);
    run_frames("t5_done", n_l + 2, 200);
    expect_frame(p_a, 8'h36);
    expect_frame(p_one, 8'h07);
    compare_frames("t5_seg", base);
    check("t5_idle_between", starts[n_s + 1] - lasts[n_l] - 1, GAP + 1);
    check("t5_no_pop_between", gap_pops, 0);
    settle(GAP + 3);

    // Reset in the middle of the payload.
    base = got.size();
    load_packet(p_std);
    for (int k = 0; k < 100 && got.size() < base + 8; k++) step();
    check("t6_reached_payload", got.size() - base, 8);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_out_valid", bus.out_valid, 0);
    check("t6_rst_in_pop",    bus.in_pop,    0);
    check("t6_rst_out_frame", bus.out_frame, 0);
    check("t6_rst_out_data",  bus.out_data,  0);
    check("t6_rst_out_last",  bus.out_last,  0);
    up_q.delete();
    stall_cnt = 0;
    drive_inputs();
    @(posedge clk);
    #1;
    base = got.size();
    n_l  = lasts.size();
    load_packet(p_one);
    rst = 1'b0;
    @(negedge clk);
    check("t6_idle_cycle_valid", bus.out_valid, 0);
    @(negedge clk);
    check("t6_first_valid", bus.out_valid, 1);
    check("t6_first_data", bus.out_data, PRE_SYM);
    run_frames("t6_done", n_l + 1, 100);
    expect_frame(p_one, 8'h07);
    compare_frames("t6_seg", base);
    settle(GAP + 3);

    check("end_pop_while_not_ready", pop_nr, 0);
    check("end_gap_quiet", gap_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/packet_framer.md
# packet_framer

Downstream stage of the segment splitter in the glove link transmit path. Pops payload segments from the splitter's FIFO-style output and emits complete line frames: preamble, sync symbol, payload, then CRC-8 over the payload. Output uses a valid/ready handshake into the line encoder/serializer. Frames are separated by a fixed idle gap so the receiver can resynchronise.

## Interface
- SEGMENT_SIZE, 4, bits per segment; legal values are 1, 2, 4 and 8. CRC width 8 must be a multiple of it.
- PREAMBLE_LENGTH, 4, preamble segments per frame, at least 1.
- PREAMBLE_SYMBOL, 4'h5, preamble segment value (SEGMENT_SIZE bits).
- SYNC_SYMBOL, 4'hD, sync segment value; must differ from PREAMBLE_SYMBOL.
- GAP_CYCLES, 2, idle cycles after each frame, at least 0.
- clk  in  1  single clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- in_nempty  in  1  upstream has a segment available.
- in_data  in  SEGMENT_SIZE  current upstream segment.
- in_end  in  1  current upstream segment is the last of its packet.
- in_pop  out  1  consume the upstream segment this cycle; combinational.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_data  out  SEGMENT_SIZE  frame segment.
- out_frame  out  1  high from the first preamble segment through the last CRC segment.
- out_last  out  1  marks the final CRC segment of the frame; qualified by out_valid.

## Operation
- A transfer occurs when out_valid && out_ready. All counters and state advance only on transfers, except in IDLE and GAP.
- States: IDLE, PREAMBLE, SYNC, PAYLOAD, CRC, GAP.
  - IDLE: out_valid=0, in_pop=0. If in_nempty, go to PREAMBLE with count=0 and crc=8'h00.
  - PREAMBLE: out_data=PREAMBLE_SYMBOL, out_valid=1.
    - Each transfer increments count.
    - On the transfer at count=PREAMBLE_LENGTH-1, go to SYNC.
  - SYNC: out_data=SYNC_SYMBOL, out_valid=1. A transfer moves to PAYLOAD.
  - PAYLOAD: combinational pass-through.
    - out_valid=in_nempty, out_data=in_data, in_pop=in_nempty && out_ready.
    - On each pop, crc is updated with in_data.
    - A pop with in_end=1 moves to CRC with count=0.
    - If in_nempty=0, out_valid=0 and the frame stalls with no timeout. out_frame stays high.
  - CRC: out_valid=1. out_data = crc[7-count*SEGMENT_SIZE -: SEGMENT_SIZE], most significant segment first.
    - out_last=1 when count=8/SEGMENT_SIZE-1.
    - A transfer at the last segment goes to GAP with count=0, or straight to IDLE if GAP_CYCLES=0.
  - GAP: out_valid=0, out_frame=0, in_pop=0. count increments every cycle; at GAP_CYCLES-1 go to IDLE.
- CRC definition:
  - Polynomial x^8+x^2+x+1 (0x07), init 0x00, no reflection, no final XOR.
  - Each segment's bits are shifted in MSB first, in segment arrival order.
  - Over byte-aligned data delivered high nibble first, this equals CRC-8/SMBUS.
- in_pop is never asserted outside PAYLOAD. Segments present during PREAMBLE, SYNC or GAP wait upstream.
- in_end is sampled only on pop cycles.
- A packet that ends on its first segment is legal: payload length 1.

## Timing
- Reset values: state=IDLE, in_pop=0, out_valid=0, out_data=0, out_frame=0, out_last=0, crc=0, count=0.
- Reset mid-frame aborts the frame immediately. Any partially consumed upstream packet is not recovered by this block.
- First out_valid comes 1 cycle after in_nempty is seen high in IDLE.
- With out_ready and in_nempty held high, a frame of N payload segments occupies PREAMBLE_LENGTH+1+N+8/SEGMENT_SIZE consecutive valid cycles. These are followed by GAP_CYCLES gap cycles and 1 IDLE cycle before the next preamble.
- out_ready low freezes out_data, out_valid and the state. Exception: in PAYLOAD, out_data follows in_data, and upstream holds in_data while it is not popped.
- The CRC register update is registered. The CRC value emitted in CRC state includes the final payload segment.
- count is sized for max(PREAMBLE_LENGTH, 8/SEGMENT_SIZE, GAP_CYCLES) and never wraps within a state.

## Test plan
- Reset, then drive payload "123456789" as 18 nibbles (3,1,3,2,...,3,9, in_end on 9) with out_ready=1.
  - Required output: 5,5,5,5,D, then the 18 payload nibbles, then F,4 with out_last on the 4.
  - Then 2 gap cycles with out_valid=0.
- Single segment 0x0 with in_end=1 -> output 5,5,5,5,D,0,0,0; out_last on the 8th valid segment; 9 payload+CRC pops total = 1.
- Toggle out_ready randomly (50%) during the frame from the first test.
  - Required: identical segment sequence.
  - No in_pop while out_ready=0.
  - No segment dropped or duplicated.
- Deassert in_nempty for 5 cycles mid-payload.
  - Required: out_valid=0 and out_frame=1 during the stall.
  - Frame and CRC identical to the unstalled case.
- Two back-to-back packets already queued upstream.
  - Required: second preamble starts exactly GAP_CYCLES+1 cycles after the first frame's out_last transfer.
  - in_pop stays low throughout that interval.
- Assert rst during PAYLOAD.
  - Required: all outputs go to their reset values asynchronously, and state returns to IDLE.
  - After release with in_nempty=1, a fresh preamble starts after 1 cycle and the CRC restarts from 0x00.
